tag_lookup_ctrl: RTL

//  Sequencer for a direct-mapped cache tag RAM with synchronous read (address registered on clock, data valid next cycle).

---
 rtl/tag_lookup_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/tag_lookup_ctrl.sv
// Direct-mapped tag RAM sequencer: post-reset valid sweep, lookup/compare, miss refill handshake and tag update.
// Optional hit/miss statistics are built when the STATS_EN macro is defined.
module tag_lookup_ctrl #(
    parameter int IDX_W = 3,
    parameter int TAG_W = 13,
    parameter int CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [TAG_W+IDX_W-1:0] req_addr,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic                   refill_req,
    input  logic                   refill_ack,
    output logic                   busy,
    output logic [IDX_W-1:0]       tram_addr,
    output logic [TAG_W:0]         tram_din,
    output logic                   tram_we,
    input  logic [TAG_W:0]         tram_dout
`ifdef STATS_EN
    ,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count
`endif
);

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_LOOKUP  = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_REFILL  = 3'd4;
    localparam logic [2:0] S_UPDATE  = 3'd5;

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_sweep;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_vld_p0;
    logic             r_hit_p0;
    logic             w_hit;

    assign w_hit     = tram_dout[TAG_W] & (tram_dout[TAG_W-1:0] == r_tag);
    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);

    // Control path: state, sweep counter and the response/refill flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_sweep    <= '0;
            r_vld_p0   <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            refill_req <= 1'b0;
        end else begin
            r_vld_p0   <= 1'b0;
            resp_valid <= r_vld_p0;
            resp_hit   <= r_vld_p0 & r_hit_p0;
            case (r_state)
                S_INIT: begin
                    r_sweep <= r_sweep + IDX_W'(1);
                    if (r_sweep == '1) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (req_valid) r_state <= S_LOOKUP;
                end
                S_LOOKUP: r_state <= S_COMPARE;
                S_COMPARE: begin
                    if (w_hit) begin
                        r_state  <= S_IDLE;
                        r_vld_p0 <= 1'b1;
                    end else begin
                        r_state    <= S_REFILL;
                        refill_req <= 1'b1;
                    end
                end
                S_REFILL: begin
                    if (refill_ack) begin
                        refill_req <= 1'b0;
                        r_state    <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_state  <= S_IDLE;
                    r_vld_p0 <= 1'b1;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    // Data path: request capture and compare result, no reset needed
    always_ff @(posedge clock) begin
        if (r_state == S_IDLE && req_valid) {r_tag, r_idx} <= req_addr;
        if (r_state == S_COMPARE)     r_hit_p0 <= w_hit;
        else if (r_state == S_UPDATE) r_hit_p0 <= 1'b0;
    end

    always_comb begin
        tram_we   = 1'b0;
        tram_addr = r_idx;
        tram_din  = '0;
        case (r_state)
            S_INIT: begin
                tram_we   = 1'b1;
                tram_addr = r_sweep;
            end
            S_UPDATE: begin
                tram_we  = 1'b1;
                tram_din = {1'b1, r_tag};
            end
            default: ;
        endcase
    end

`ifdef STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Counters advance on the same edge that raises resp_valid
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_vld_p0) begin
            if (r_hit_p0) hit_count  <= sat_inc(hit_count);
            else          miss_count <= sat_inc(miss_count);
        end
    end
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule
